// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//
// Pipelined adder/subtractor with a carry chain cut into CHUNK-bit slices.
// Stage k adds slice k and registers its carry for stage k+1. Operand bits
// for later slices travel alongside in skew registers. Finished low slices
// ride forward with the partial sum, so all bits of a result leave together.
// The final stage also computes the signed overflow flag and, if SATURATE
// is set, clamps the result.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. valid must not depend on ready. Here in_ready is
// out_ready | ~out_valid, so the whole pipe advances together or holds.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all stages and outputs
//   in_valid   operation present on a, b, opcode
//   in_ready   block accepts an operation this cycle
//   a, b       WIDTH-bit operands
//   opcode     0 = a + b, 1 = a - b
//   out_valid  result present on sum, c_out, over
//   out_ready  downstream accepts the result this cycle
//   sum        WIDTH-bit result (wrapped or saturated)
//   c_out      carry out of the MSB (for subtract: 1 = no borrow)
//   over       signed two's-complement overflow
//
// WIDTH must be a multiple of CHUNK. Latency is WIDTH/CHUNK advancing edges.
module pipelined_addsub #(
    parameter int WIDTH    = 16,
    parameter int CHUNK    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             over
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];   // holds b' (already inverted for subtract)
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];   // partial sum; slices 0..k valid in stage k
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              over_q, over_d;
    logic              adv;

    assign adv = out_ready | ~valid_q[STAGES-1];

    always_comb begin : next_state
        logic             src_valid;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] new_sum;
        logic             src_c;
        logic [CHUNK:0]   slice;
        logic             ovf;
        int               kp;

        src_valid = 1'b0;
        src_a     = '0;
        src_b     = '0;
        src_sum   = '0;
        new_sum   = '0;
        src_c     = 1'b0;
        slice     = '0;
        ovf       = 1'b0;
        kp        = 0;

        valid_d = valid_q;
        carry_d = carry_q;
        over_d  = over_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end

        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                kp = (k == 0) ? 0 : k - 1;
                if (k == 0) begin
                    // Subtract is a + ~b + 1: invert b once here, carry-in = opcode.
                    src_valid = in_valid;
                    src_a     = a;
                    src_b     = opcode ? ~b : b;
                    src_c     = opcode;
                    src_sum   = '0;
                end else begin
                    src_valid = valid_q[kp];
                    src_a     = a_q[kp];
                    src_b     = b_q[kp];
                    src_c     = carry_q[kp];
                    src_sum   = sum_q[kp];
                end

                slice = {1'b0, src_a[k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c};
                new_sum = src_sum;
                new_sum[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];

                if (k == STAGES - 1) begin
                    // Signed overflow: operands agree in sign, result does not.
                    ovf    = (src_a[MSB] == src_b[MSB]) && (new_sum[MSB] != src_a[MSB]);
                    over_d = ovf;
                    if ((SATURATE != 0) && ovf) begin
                        new_sum = src_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end

                valid_d[k] = src_valid;
                carry_d[k] = slice[CHUNK];
                a_d[k]     = src_a;
                b_d[k]     = src_b;
                sum_d[k]   = new_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            over_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            over_q  <= over_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign over      = over_q;

endmodule
